// File: rtl/alu4_out_stage.sv
// Registered output stage of the 4-bit ALU: derives N/Z/C/V at capture and
// buffers up to two results behind a valid/ready handshake.
module alu4_out_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] y,
  input  logic [2:0] op,
  input  logic       c,
  input  logic       v,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_y,
  output logic [2:0] out_op,
  output logic [3:0] out_flags,
  output logic [1:0] count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [10:0] mem [2];
  logic        head;
  logic        tail;
  logic        push;
  logic        pop;
  logic [3:0]  flags;

  // Logic ops (op[2] = 0) never produce a meaningful carry or overflow.
  assign flags = {y[3], (y == 4'b0000), op[2] & c, op[2] & v};

  // Handshake depends only on registered state, so no path from out_ready to in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign count     = state;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign {out_y, out_op, out_flags} = mem[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= 1'b0;
      tail  <= 1'b0;
      // NOTE: the storage is reset too, because out_* drive the head entry
      // directly and must read as zero after reset.
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= {y, op, flags};
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case (state)
        EMPTY: if (push) state <= ONE;
        ONE: begin
          if (push && !pop)      state <= FULL;
          else if (pop && !push) state <= EMPTY;
        end
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_out_stage.sv
// Scoreboard bench for alu4_out_stage: a queue-based reference model is fed
// on every accepted input and checked against every presented output.
module tb_alu4_out_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y;
  logic [2:0] op;
  logic       c;
  logic       v;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic [2:0] out_op;
  logic [3:0] out_flags;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  logic [10:0] sb [$];

  alu4_out_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .op        (op),
    .c         (c),
    .v         (v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_op    (out_op),
    .out_flags (out_flags),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted result is {y, op, N, Z, C, V}; C/V only count for arithmetic selects.
  function automatic logic [10:0] expected_entry(input logic [3:0] ry, input logic [2:0] rop,
                                                 input logic rc, input logic rv);
    logic n, z, cf, vf;
    n  = (ry >= 4'd8);
    z  = (ry == 0);
    cf = (rop >= 3'd4) ? rc : 1'b0;
    vf = (rop >= 3'd4) ? rv : 1'b0;
    return {ry, rop, n, z, cf, vf};
  endfunction

  // Monitor: evaluates the handshakes that will fire on the coming rising edge.
  initial begin
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      check("count", count, sb.size());
      check("in_ready", in_ready, sb.size() < 2);
      check("out_valid", out_valid, sb.size() != 0);
      if (out_valid && sb.size() != 0)
        check("head", {out_y, out_op, out_flags}, sb[0]);
      if (reset) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
        if (in_valid && in_ready) sb.push_back(expected_entry(y, op, c, v));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [3:0] py, input logic [2:0] pop_sel, input logic pc, input logic pv);
    in_valid = 1'b1;
    y = py; op = pop_sel; c = pc; v = pv;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int budget;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    y = 4'h5; op = 3'b101; c = 1'b1; v = 1'b1;

    // Reset with in_valid held: nothing captured, outputs at zero.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_flags", out_flags, 0);
    end
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("idle_count", count, 0);

    // Flag derivation
    out_ready = 1'b1;
    push1(4'h0, 3'b000, 1'b1, 1'b1);
    check("flags_zero_logic", out_flags, 4'b0100);
    step();
    push1(4'h9, 3'b110, 1'b1, 1'b1);
    check("flags_neg_arith", out_flags, 4'b1011);
    step();

    // Fill and stall
    out_ready = 1'b0;
    push1(4'h3, 3'b001, 1'b0, 1'b0);
    push1(4'h5, 3'b010, 1'b0, 1'b0);
    check("full_count", count, 2);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1; y = 4'h7;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_out_y", out_y, 4'h3);
    end
    in_valid = 1'b0;

    // Drain from FULL: no push admitted in the first pop cycle
    out_ready = 1'b1;
    check("drain_in_ready", in_ready, 0);
    step();
    check("drain_count1", count, 1);
    check("drain_y2", out_y, 4'h5);
    step();
    check("drain_count0", count, 0);

    // Streaming: one per cycle, occupancy pinned at 1
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      y = 4'(i); op = 3'($urandom_range(7)); c = 1'($urandom); v = 1'($urandom);
      step();
      check("stream_count", count, 1);
      check("stream_out_y", out_y, i);
    end
    in_valid = 1'b0;
    step();

    // Reset mid-stream discards buffered entries
    out_ready = 1'b0;
    push1(4'hA, 3'b100, 1'b1, 1'b0);
    push1(4'hB, 3'b011, 1'b1, 1'b1);
    check("pre_rst_count", count, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    out_ready = 1'b1;
    push1(4'hC, 3'b111, 1'b0, 1'b1);
    check("after_rst_first", out_y, 4'hC);
    step();

    // Randomized traffic, scoreboard-checked
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      y = 4'($urandom); op = 3'($urandom); c = 1'($urandom); v = 1'($urandom);
      reset = ($urandom_range(60) == 0);
      step();
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    budget = 0;
    while (count != 0 && budget < 10) begin
      step();
      budget++;
    end
    check("final_drain", count, 0);

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
